// File: rtl/dma_wr_desc_arb.sv
// rtl/dma_wr_desc_arb.sv - round-robin write-descriptor arbiter with per-port outstanding limits and status routing
module dma_wr_desc_arb #(
    parameter int PORTS           = 4,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int RAM_SEL_WIDTH   = 2,
    parameter int RAM_ADDR_WIDTH  = 19,
    parameter int LEN_WIDTH       = 16,
    parameter int S_TAG_WIDTH     = 6,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]     s_axis_write_desc_pcie_addr,
    input  logic [PORTS*RAM_SEL_WIDTH-1:0]       s_axis_write_desc_ram_sel,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]      s_axis_write_desc_ram_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_write_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]         s_axis_write_desc_tag,
    input  logic [PORTS-1:0]                     s_axis_write_desc_valid,
    output logic [PORTS-1:0]                     s_axis_write_desc_ready,
    output logic [PCIE_ADDR_WIDTH-1:0]           m_axis_write_desc_pcie_addr,
    output logic [RAM_SEL_WIDTH-1:0]             m_axis_write_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]            m_axis_write_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]                 m_axis_write_desc_len,
    output logic [M_TAG_WIDTH-1:0]               m_axis_write_desc_tag,
    output logic                                 m_axis_write_desc_valid,
    input  logic                                 m_axis_write_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]               s_axis_write_desc_status_tag,
    input  logic                                 s_axis_write_desc_status_valid,
    output logic [PORTS*S_TAG_WIDTH-1:0]         m_axis_write_desc_status_tag,
    output logic [PORTS-1:0]                     m_axis_write_desc_status_valid,
    output logic [PORTS-1:0]                     busy
);

    localparam int IDX_W = M_TAG_WIDTH - S_TAG_WIDTH;
    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   probe_idx;
    logic               grant_found;
    logic               accept;
    logic [PORTS-1:0]   eligible;
    logic [PORTS-1:0]   inc;
    logic [PORTS-1:0]   dec;
    logic [CNT_W-1:0]   count     [PORTS];
    logic [CNT_W-1:0]   count_nxt [PORTS];
    logic [IDX_W-1:0]   st_idx;
    logic               st_in_range;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = s_axis_write_desc_valid[i] && (int'(count[i]) < MAX_OUTSTANDING);
        end
    end

    // First eligible port at or after the pointer, wrapping modulo PORTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe_idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            probe_idx = PTR_W'((int'(rr_ptr) + k) % PORTS);
            if (!grant_found && eligible[probe_idx]) begin
                grant_found = 1'b1;
                grant_idx   = probe_idx;
            end
        end
    end

    assign accept = (state == IDLE) && grant_found && !rst;
    assign s_axis_write_desc_ready = accept ? ({{(PORTS-1){1'b0}}, 1'b1} << grant_idx) : '0;

    assign st_idx      = s_axis_write_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
    assign st_in_range = int'(st_idx) < PORTS;

    // Statuses for idle ports are discarded so counts cannot underflow.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            inc[i] = accept && (grant_idx == PTR_W'(i));
            dec[i] = s_axis_write_desc_status_valid && st_in_range &&
                     (st_idx == IDX_W'(i)) && (count[i] != '0);
            count_nxt[i] = count[i];
            if (inc[i] && !dec[i]) begin
                count_nxt[i] = count[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                count_nxt[i] = count[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            rr_ptr                  <= '0;
            m_axis_write_desc_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state                   <= HOLD;
                        m_axis_write_desc_valid <= 1'b1;
                        rr_ptr <= (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + PTR_W'(1);
                    end
                end
                HOLD: begin
                    if (m_axis_write_desc_ready) begin
                        state                   <= IDLE;
                        m_axis_write_desc_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORTS; i++) begin
                count[i] <= '0;
            end
            busy                           <= '0;
            m_axis_write_desc_status_valid <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                count[i] <= count_nxt[i];
                busy[i]  <= (count_nxt[i] != '0);
            end
            m_axis_write_desc_status_valid <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            m_axis_write_desc_pcie_addr <= s_axis_write_desc_pcie_addr[grant_idx*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
            m_axis_write_desc_ram_sel   <= s_axis_write_desc_ram_sel[grant_idx*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
            m_axis_write_desc_ram_addr  <= s_axis_write_desc_ram_addr[grant_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            m_axis_write_desc_len       <= s_axis_write_desc_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
            m_axis_write_desc_tag       <= {IDX_W'(grant_idx), s_axis_write_desc_tag[grant_idx*S_TAG_WIDTH +: S_TAG_WIDTH]};
        end
        for (int i = 0; i < PORTS; i++) begin
            if (dec[i]) begin
                m_axis_write_desc_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] <= s_axis_write_desc_status_tag[S_TAG_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dma_wr_desc_arb.sv
// tb/tb_dma_wr_desc_arb.sv - self-checking bench for dma_wr_desc_arb
module tb_dma_wr_desc_arb;

    localparam int P   = 4;
    localparam int AW  = 64;
    localparam int SW  = 2;
    localparam int RW  = 19;
    localparam int LW  = 16;
    localparam int TW  = 6;
    localparam int MTW = 9;
    localparam int MO  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P*AW-1:0] s_addr = '0;
    logic [P*SW-1:0] s_sel  = '0;
    logic [P*RW-1:0] s_raddr = '0;
    logic [P*LW-1:0] s_len  = '0;
    logic [P*TW-1:0] s_tag  = '0;
    logic [P-1:0]    s_valid = '0;
    logic [P-1:0]    s_ready;
    logic [AW-1:0]   m_addr;
    logic [SW-1:0]   m_sel;
    logic [RW-1:0]   m_raddr;
    logic [LW-1:0]   m_len;
    logic [MTW-1:0]  m_tag;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [MTW-1:0]  st_tag = '0;
    logic            st_valid = 1'b0;
    logic [P*TW-1:0] ms_tag;
    logic [P-1:0]    ms_valid;
    logic [P-1:0]    busy;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] d_addr  [P];
    logic [SW-1:0] d_sel   [P];
    logic [RW-1:0] d_raddr [P];
    logic [LW-1:0] d_len   [P];
    logic [TW-1:0] d_tag   [P];

    dma_wr_desc_arb #(
        .PORTS(P), .PCIE_ADDR_WIDTH(AW), .RAM_SEL_WIDTH(SW), .RAM_ADDR_WIDTH(RW),
        .LEN_WIDTH(LW), .S_TAG_WIDTH(TW), .M_TAG_WIDTH(MTW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_write_desc_pcie_addr(s_addr),
        .s_axis_write_desc_ram_sel(s_sel),
        .s_axis_write_desc_ram_addr(s_raddr),
        .s_axis_write_desc_len(s_len),
        .s_axis_write_desc_tag(s_tag),
        .s_axis_write_desc_valid(s_valid),
        .s_axis_write_desc_ready(s_ready),
        .m_axis_write_desc_pcie_addr(m_addr),
        .m_axis_write_desc_ram_sel(m_sel),
        .m_axis_write_desc_ram_addr(m_raddr),
        .m_axis_write_desc_len(m_len),
        .m_axis_write_desc_tag(m_tag),
        .m_axis_write_desc_valid(m_valid),
        .m_axis_write_desc_ready(m_ready),
        .s_axis_write_desc_status_tag(st_tag),
        .s_axis_write_desc_status_valid(st_valid),
        .m_axis_write_desc_status_tag(ms_tag),
        .m_axis_write_desc_status_valid(ms_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_desc(input int p, input logic v, input logic [AW-1:0] a, input logic [SW-1:0] sel,
                            input logic [RW-1:0] ra, input logic [LW-1:0] len, input logic [TW-1:0] tag);
        s_valid[p]          = v;
        s_addr[p*AW +: AW]  = a;
        s_sel[p*SW +: SW]   = sel;
        s_raddr[p*RW +: RW] = ra;
        s_len[p*LW +: LW]   = len;
        s_tag[p*TW +: TW]   = tag;
        d_addr[p] = a; d_sel[p] = sel; d_raddr[p] = ra; d_len[p] = len; d_tag[p] = tag;
    endtask

    task automatic clear_inputs();
        s_valid  = '0;
        m_ready  = 1'b0;
        st_valid = 1'b0;
        st_tag   = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s_valid = '1;
        @(negedge clk); #1;
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy); end
        checks++; if (ms_valid !== 4'b0000) begin errors++; $display("FAIL reset_status_valid got=%b exp=0000", ms_valid); end
        apply_reset();
    endtask

    task automatic test_rr_order();
        int n = 0;
        logic [MTW-1:0] exp_tag;
        apply_reset();
        for (int i = 0; i < P; i++) set_desc(i, 1'b1, 64'h1000 * (i + 1), SW'(i), RW'(i * 3), LW'(64 + i), TW'(10 + i));
        m_ready = 1'b1;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk); #1;
            if (m_valid) begin
                exp_tag = {3'(n % 4), 6'(10 + (n % 4))};
                checks++; if (m_tag !== exp_tag) begin errors++; $display("FAIL rr_tag grant=%0d got=%h exp=%h", n, m_tag, exp_tag); end
                checks++; if (m_addr !== 64'h1000 * ((n % 4) + 1)) begin errors++; $display("FAIL rr_addr grant=%0d got=%h", n, m_addr); end
                n++;
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rr_timeout grants=%0d exp=5", n); end
        clear_inputs();
    endtask

    task automatic test_hold();
        int pulses = 0;
        apply_reset();
        m_ready = 1'b0;
        set_desc(2, 1'b1, 64'hDEAD_BEEF_0000_1234, 2'd3, 19'h12345, 16'h0200, 6'h2A);
        #1;
        checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL hold_first_ready got=%b exp=0100", s_ready); end
        repeat (5) begin
            @(negedge clk); #1;
            if (s_ready[2]) pulses++;
            checks++;
            if (m_valid !== 1'b1 || m_tag !== {3'd2, 6'h2A} || m_addr !== 64'hDEAD_BEEF_0000_1234 ||
                m_sel !== 2'd3 || m_raddr !== 19'h12345 || m_len !== 16'h0200) begin
                errors++; $display("FAIL hold_stable valid=%b tag=%h addr=%h len=%h", m_valid, m_tag, m_addr, m_len);
            end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL hold_extra_ready got=%0d exp=0", pulses); end
        s_valid = '0;
        m_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", m_valid); end
        clear_inputs();
    endtask

    task automatic test_outstanding();
        int acc = 0;
        apply_reset();
        m_ready = 1'b1;
        set_desc(1, 1'b1, 64'h55, 2'd1, 19'h100, 16'h40, 6'h05);
        repeat (8) begin
            #1; if (s_ready[1]) acc++;
            @(negedge clk);
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL limit_accepts got=%0d exp=2", acc); end
        #1;
        checks++; if (s_ready[1] !== 1'b0) begin errors++; $display("FAIL limit_ready got=%b exp=0", s_ready[1]); end
        checks++; if (busy !== 4'b0010) begin errors++; $display("FAIL limit_busy got=%b exp=0010", busy); end
        st_tag = 9'h045; st_valid = 1'b1;
        #1;
        checks++; if (s_ready[1] !== 1'b0) begin errors++; $display("FAIL limit_same_cycle got=%b exp=0", s_ready[1]); end
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++; if (ms_valid !== 4'b0010) begin errors++; $display("FAIL status_route_valid got=%b exp=0010", ms_valid); end
        checks++; if (ms_tag[TW +: TW] !== 6'h05) begin errors++; $display("FAIL status_route_tag got=%h exp=05", ms_tag[TW +: TW]); end
        checks++; if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL limit_reaccept got=%b exp=1", s_ready[1]); end
        @(negedge clk);
        s_valid = '0;
        #1;
        checks++; if (ms_valid !== 4'b0000) begin errors++; $display("FAIL status_one_pulse got=%b exp=0000", ms_valid); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        m_ready = 1'b1;
        set_desc(0, 1'b1, 64'h10, 2'd0, 19'h0, 16'h8, 6'h01);
        #1;
        checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL simul_first got=%b exp=0001", s_ready); end
        @(negedge clk); s_valid = '0;
        @(negedge clk);
        set_desc(0, 1'b1, 64'h20, 2'd0, 19'h0, 16'h8, 6'h02);
        st_tag = {3'd0, 6'h01}; st_valid = 1'b1;
        #1;
        checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL simul_accept got=%b exp=0001", s_ready); end
        @(negedge clk);
        s_valid = '0; st_valid = 1'b0;
        #1;
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL simul_busy got=%b exp=1", busy[0]); end
        checks++; if (ms_valid !== 4'b0001) begin errors++; $display("FAIL simul_status got=%b exp=0001", ms_valid); end
        @(negedge clk);
        st_tag = {3'd0, 6'h02}; st_valid = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL simul_count_one got=%b exp=0000", busy); end
        st_valid = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++; if (ms_valid !== 4'b0000) begin errors++; $display("FAIL underflow_drop got=%b exp=0000", ms_valid); end
        clear_inputs();
    endtask

    task automatic test_bad_index();
        apply_reset();
        m_ready = 1'b1;
        set_desc(3, 1'b1, 64'h30, 2'd2, 19'h30, 16'h30, 6'h33);
        @(negedge clk); s_valid = '0;
        @(negedge clk); #1;
        checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL badidx_setup got=%b exp=1000", busy); end
        st_tag = {3'd7, 6'h11}; st_valid = 1'b1;
        @(negedge clk);
        st_tag = {3'd4, 6'h12};
        #1;
        checks++; if (ms_valid !== 4'b0000) begin errors++; $display("FAIL badidx7_pulse got=%b exp=0000", ms_valid); end
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++; if (ms_valid !== 4'b0000) begin errors++; $display("FAIL badidx4_pulse got=%b exp=0000", ms_valid); end
        checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL badidx_count got=%b exp=1000", busy); end
        clear_inputs();
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        m_ready = 1'b0;
        set_desc(1, 1'b1, 64'h77, 2'd1, 19'h77, 16'h77, 6'h07);
        @(negedge clk); #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rsthold_setup got=%b exp=1", m_valid); end
        s_valid = '0;
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rsthold_async_valid got=%b exp=0", m_valid); end
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rsthold_busy got=%b exp=0000", busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < P; i++) set_desc(i, 1'b1, 64'h0, 2'd0, 19'h0, 16'h0, TW'(i));
        m_ready = 1'b1;
        st_tag = 9'h045; st_valid = 1'b1;
        #1;
        checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL rsthold_ptr got=%b exp=0001", s_ready); end
        @(negedge clk);
        s_valid = '0; st_valid = 1'b0;
        #1;
        checks++; if (ms_valid !== 4'b0000) begin errors++; $display("FAIL rsthold_stale_status got=%b exp=0000", ms_valid); end
        clear_inputs();
    endtask

    task automatic test_random();
        bit            mh = 0;
        int            mptr = 0;
        int            mcnt [P];
        logic [MTW-1:0] h_tag;
        logic [AW-1:0] h_addr;
        logic [SW-1:0] h_sel;
        logic [RW-1:0] h_raddr;
        logic [LW-1:0] h_len;
        logic [P-1:0]  exp_sv = '0;
        logic [TW-1:0] exp_st [P];
        logic [P-1:0]  exp_ready;
        logic [P-1:0]  exp_busy;
        int g;
        int idx;
        apply_reset();
        for (int i = 0; i < P; i++) begin mcnt[i] = 0; exp_st[i] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < P; i++)
                set_desc(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, SW'($urandom), RW'($urandom), LW'($urandom), TW'($urandom));
            m_ready  = ($urandom_range(0, 3) != 0);
            st_valid = ($urandom_range(0, 2) == 0);
            st_tag   = MTW'($urandom);
            #1;
            g = -1;
            exp_ready = '0;
            if (!mh) begin
                for (int k = 0; k < P; k++) begin
                    if (g < 0 && s_valid[(mptr + k) % P] && mcnt[(mptr + k) % P] < MO) g = (mptr + k) % P;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            for (int i = 0; i < P; i++) exp_busy[i] = (mcnt[i] != 0);
            checks++; if (s_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
            checks++; if (m_valid !== mh) begin errors++; $display("FAIL rand_m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, mh); end
            if (mh) begin
                checks++;
                if (m_tag !== h_tag || m_addr !== h_addr || m_sel !== h_sel || m_raddr !== h_raddr || m_len !== h_len) begin
                    errors++; $display("FAIL rand_fields cyc=%0d tag=%h/%h addr=%h/%h len=%h/%h", cyc, m_tag, h_tag, m_addr, h_addr, m_len, h_len);
                end
            end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            checks++; if (ms_valid !== exp_sv) begin errors++; $display("FAIL rand_status_valid cyc=%0d got=%b exp=%b", cyc, ms_valid, exp_sv); end
            for (int i = 0; i < P; i++) begin
                if (exp_sv[i]) begin
                    checks++;
                    if (ms_tag[i*TW +: TW] !== exp_st[i]) begin errors++; $display("FAIL rand_status_tag cyc=%0d port=%0d got=%h exp=%h", cyc, i, ms_tag[i*TW +: TW], exp_st[i]); end
                end
            end
            exp_sv = '0;
            if (st_valid) begin
                idx = int'(st_tag) / (1 << TW);
                if (idx < P && mcnt[idx] > 0) begin
                    mcnt[idx]--;
                    exp_sv[idx] = 1'b1;
                    exp_st[idx] = st_tag[TW-1:0];
                end
            end
            if (g >= 0) begin
                mh = 1; mcnt[g]++; mptr = (g + 1) % P;
                h_tag = {3'(g), d_tag[g]}; h_addr = d_addr[g]; h_sel = d_sel[g]; h_raddr = d_raddr[g]; h_len = d_len[g];
            end else if (mh && m_ready) begin
                mh = 0;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rr_order();
        test_hold();
        test_outstanding();
        test_simultaneous();
        test_bad_index();
        test_reset_in_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_wr_desc_arb.md
DMA_WR_DESC_ARB -- requirements
Module: dma_wr_desc_arb

Interface
REQ-001 SHALL: parameter PORTS, default 4, number of requester channels (2..8).
REQ-002 SHALL: parameter PCIE_ADDR_WIDTH, default 64, PCIe address width.
REQ-003 SHALL: parameter RAM_SEL_WIDTH, default 2, RAM select width.
REQ-004 SHALL: parameter RAM_ADDR_WIDTH, default 19, RAM byte address width.
REQ-005 SHALL: parameter LEN_WIDTH, default 16, transfer length width in bytes.
REQ-006 SHALL: parameter S_TAG_WIDTH, default 6, requester tag width.
REQ-007 SHALL: parameter M_TAG_WIDTH, default S_TAG_WIDTH+$clog2(PORTS), engine tag width.
REQ-008 SHALL: parameter MAX_OUTSTANDING, default 8, per-port in-flight descriptor limit (1..255).
REQ-009 SHALL: clk  in  1  single clock; all logic rising-edge.
REQ-010 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-011 SHALL: s_axis_write_desc_pcie_addr / _ram_sel / _ram_addr / _len / _tag  in  PORTS*field width  per-port descriptor fields; port i at slice i.
REQ-012 SHALL: s_axis_write_desc_valid  in  PORTS  per-port valid; s_axis_write_desc_ready  out  PORTS  per-port ready.
REQ-013 SHALL: m_axis_write_desc_pcie_addr / _ram_sel / _ram_addr / _len  out  field width  descriptor to the write engine.
REQ-014 SHALL: m_axis_write_desc_tag  out  M_TAG_WIDTH  {port index, requester tag}.
REQ-015 SHALL: m_axis_write_desc_valid  out  1; m_axis_write_desc_ready  in  1.
REQ-016 SHALL: s_axis_write_desc_status_tag  in  M_TAG_WIDTH; s_axis_write_desc_status_valid  in  1  completion from engine.
REQ-017 SHALL: m_axis_write_desc_status_tag  out  PORTS*S_TAG_WIDTH; m_axis_write_desc_status_valid  out  PORTS  per-port completion.
REQ-018 SHALL: busy  out  PORTS  port has >=1 descriptor in flight.

Function
REQ-019 SHALL: port i is eligible when valid[i]=1 and outstanding count[i] < MAX_OUTSTANDING.
REQ-020 SHALL: FSM states IDLE and HOLD; IDLE with any eligible port grants exactly one port, latches its fields into the output register, asserts ready[i] for that cycle only, enters HOLD.
REQ-021 SHALL: grant is round-robin: search starts at last granted index +1 modulo PORTS; after reset the pointer starts at port 0.
REQ-022 SHALL: in HOLD, m_axis_write_desc_valid=1 and all fields stable until m_axis_write_desc_ready=1; on that handshake return to IDLE (next grant no earlier than the following cycle).
REQ-023 SHALL: descriptor latency: valid[i] at edge N accepted at edge N (ready[i]=1 combinationally in IDLE), output valid from edge N+1.
REQ-024 SHALL: no s_axis ready asserted while in HOLD.
REQ-025 SHALL: count[i] increments on acceptance of a port-i descriptor, decrements on status_valid with status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH]=i; simultaneous increment and decrement leaves count unchanged.
REQ-026 SHALL: status with out-of-range port index (>=PORTS) or count already 0 is dropped; counts never underflow or exceed MAX_OUTSTANDING.
REQ-027 SHALL: status routing is registered: m_axis_write_desc_status_valid[i] pulses one cycle after input, tag = status_tag[S_TAG_WIDTH-1:0]; other ports' valid stay 0.
REQ-028 SHALL: busy[i] = (count[i] != 0), registered with the counter.

Reset
REQ-029 SHALL: on rst: FSM=IDLE, all counts 0, RR pointer 0, m_axis_write_desc_valid=0, all status valids 0, all ready 0, busy 0; data registers need not reset.
REQ-030 SHALL: rst asserted mid-HOLD drops the pending descriptor; in-flight statuses arriving after reset are dropped per REQ-026.

Verification
REQ-031 SHALL: ports 0..3 valid continuously, m_ready=1 -> grant order 0,1,2,3,0 with tags {0,t0},{1,t1},{2,t2},{3,t3}.
REQ-032 SHALL: port 2 valid, m_ready=0 for 5 cycles -> m_valid high, fields stable 5 cycles, ready[2] pulsed once only.
REQ-033 SHALL: MAX_OUTSTANDING=2, port 1 issues 2 descriptors without status -> third held (ready[1]=0) until status tag 8'h45 arrives, then accepted; status output port 1 tag 6'h05 one cycle later.
REQ-034 SHALL: acceptance on port 0 and status for port 0 in the same cycle with count=1 -> count stays 1, busy[0]=1.
REQ-035 SHALL: status tag with port index 7 when PORTS=4 -> no output pulse, counts unchanged.
REQ-036 SHALL: rst pulse while in HOLD -> m_valid=0 immediately (asynchronous), all busy 0, next grant starts at port 0.
